alu64_exec: RTL and testbench

64-bit integer ALU for the execute stage of the five-stage RISC-V pipeline. It combines two operands selected by the forwarding muxes and the ALU-source mux, under a 3-bit operation code from the ID/EX register. It produces the result for the EX/MEM register, a carry-out and a zero flag for branch resolution. A registered copy of the flags is kept for status and debug.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/adder64.sv | 20 ++
 rtl/alu64_exec.sv | 87 ++++++++
 tb/tb_alu64_exec.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation codes and width shared by the execute-stage ALU
package alu_pkg;

  localparam int WIDTH = 64;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // SUB and SLT both run A + ~B + 1 through the shared adder
  function automatic logic alu_sel_subtracts(input logic [2:0] sel);
    return (sel == ALU_SUB) || (sel == ALU_SLT);
  endfunction

endpackage

// File: rtl/adder64.sv
// rtl/adder64.sv - plain combinational adder with carry in/out
module adder64 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] full_sum;

  always_comb begin
    full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    sum      = full_sum[WIDTH-1:0];
    cout     = full_sum[WIDTH];
  end

endmodule

// File: rtl/alu64_exec.sv
// rtl/alu64_exec.sv - execute-stage ALU with combinational result/flags and registered flag copy
module alu64_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             coutfin,
  output logic             z,
  output logic             z_q,
  output logic             coutfin_q
);

  logic             sub_op;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             signed_ovf;
  logic             slt_bit;
  logic [5:0]       shamt;
  logic             z_d;
  logic             coutfin_d;

  assign sub_op = alu_sel_subtracts(ALU_Sel);
  assign add_b  = sub_op ? ~B : B;
  assign shamt  = B[5:0];

  adder64 #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (A),
    .b    (add_b),
    .cin  (sub_op),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Signed less-than from the subtract path: sign of the difference corrected by overflow
  always_comb begin
    signed_ovf = (A[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
    slt_bit    = add_sum[WIDTH-1] ^ signed_ovf;
  end

  always_comb begin
    ALU_Out = '0;
    coutfin = 1'b0;
    case (ALU_Sel)
      ALU_AND: ALU_Out = A & B;
      ALU_OR:  ALU_Out = A | B;
      ALU_ADD: begin
        ALU_Out = add_sum;
        coutfin = add_cout;
      end
      ALU_XOR: ALU_Out = A ^ B;
      ALU_SLL: ALU_Out = A << shamt;
      ALU_SRL: ALU_Out = A >> shamt;
      ALU_SUB: begin
        ALU_Out = add_sum;
        coutfin = add_cout;
      end
      ALU_SLT: ALU_Out = {{(WIDTH-1){1'b0}}, slt_bit};
      default: ALU_Out = '0;
    endcase
    z = (ALU_Out == '0);
  end

  always_comb begin
    z_d       = z;
    coutfin_d = coutfin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q       <= 1'b0;
      coutfin_q <= 1'b0;
    end else begin
      z_q       <= z_d;
      coutfin_q <= coutfin_d;
    end
  end

endmodule

// File: tb/tb_alu64_exec.sv
// tb/tb_alu64_exec.sv - self-checking bench for alu64_exec with directed and random stimulus
module tb_alu64_exec;

  logic        clk;
  logic        rst;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  ALU_Sel;
  logic [63:0] ALU_Out;
  logic        coutfin;
  logic        z;
  logic        z_q;
  logic        coutfin_q;

  int n_checks = 0;
  int n_fail   = 0;

  alu64_exec #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .ALU_Sel   (ALU_Sel),
    .ALU_Out   (ALU_Out),
    .coutfin   (coutfin),
    .z         (z),
    .z_q       (z_q),
    .coutfin_q (coutfin_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, result} from plain arithmetic on the operation's meaning
  function automatic logic [64:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] sel);
    logic [64:0] wide;
    int unsigned amt;
    amt = b % 64;
    case (sel)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: begin
        wide = {1'b0, a} + {1'b0, b};
        return wide;
      end
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, a << amt};
      3'd5: return {1'b0, a >> amt};
      3'd6: return {(a >= b), a - b};
      default: return {1'b0, ($signed(a) < $signed(b)) ? 64'd1 : 64'd0};
    endcase
  endfunction

  // Drive one operation mid-cycle, check combinational outputs, then the registered flags after the edge
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] sel);
    logic [64:0] r;
    @(negedge clk);
    A = a;
    B = b;
    ALU_Sel = sel;
    r = ref_alu(a, b, sel);
    #1;
    check_eq({tag, ".out"}, ALU_Out, r[63:0]);
    check_eq({tag, ".cout"}, {63'd0, coutfin}, {63'd0, r[64]});
    check_eq({tag, ".z"}, {63'd0, z}, {63'd0, (r[63:0] == 64'd0)});
    @(posedge clk);
    #1;
    check_eq({tag, ".z_q"}, {63'd0, z_q}, {63'd0, (r[63:0] == 64'd0)});
    check_eq({tag, ".cout_q"}, {63'd0, coutfin_q}, {63'd0, r[64]});
  endtask

  task automatic run_lit(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] sel, input logic [63:0] exp_out, input logic exp_c);
    @(negedge clk);
    A = a;
    B = b;
    ALU_Sel = sel;
    #1;
    check_eq({tag, ".out"}, ALU_Out, exp_out);
    check_eq({tag, ".cout"}, {63'd0, coutfin}, {63'd0, exp_c});
    check_eq({tag, ".z"}, {63'd0, z}, {63'd0, (exp_out == 64'd0)});
  endtask

  initial begin
    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rs;
    rst = 1'b1;
    A = 64'd0;
    B = 64'd0;
    ALU_Sel = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.z_q", {63'd0, z_q}, 64'd0);
    check_eq("reset.cout_q", {63'd0, coutfin_q}, 64'd0);
    check_eq("reset.comb_z", {63'd0, z}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run_lit("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 64'd0, 1'b1);
    @(posedge clk);
    #1;
    check_eq("add_wrap.z_q", {63'd0, z_q}, 64'd1);
    check_eq("add_wrap.cout_q", {63'd0, coutfin_q}, 64'd1);

    // Async reset mid-cycle while inputs keep z and coutfin high
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.z_q", {63'd0, z_q}, 64'd0);
    check_eq("arst.cout_q", {63'd0, coutfin_q}, 64'd0);
    check_eq("arst.out", ALU_Out, 64'd0);
    check_eq("arst.cout", {63'd0, coutfin}, 64'd1);
    @(posedge clk);
    #1;
    check_eq("arst_hold.z_q", {63'd0, z_q}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("arst_resume.z_q", {63'd0, z_q}, 64'd1);
    check_eq("arst_resume.cout_q", {63'd0, coutfin_q}, 64'd1);

    run_lit("sub_eq", 64'd5, 64'd5, 3'b110, 64'd0, 1'b1);
    run_lit("sub_neg", 64'd3, 64'd5, 3'b110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_lit("slt_lt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111, 64'd1, 1'b0);
    run_lit("slt_ge", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111, 64'd0, 1'b0);
    run_lit("slt_ovf", 64'h8000_0000_0000_0000, 64'd1, 3'b111, 64'd1, 1'b0);
    run_lit("and", 64'hF0F0, 64'h0FF0, 3'b000, 64'h00F0, 1'b0);
    run_lit("or", 64'hF0F0, 64'h0FF0, 3'b001, 64'hFFF0, 1'b0);
    run_lit("xor", 64'hF0F0, 64'h0FF0, 3'b011, 64'hFF00, 1'b0);
    run_lit("sll", 64'd1, 64'h43, 3'b100, 64'h8, 1'b0);
    run_lit("srl", 64'h8000_0000_0000_0000, 64'd63, 3'b101, 64'd1, 1'b0);
    run_lit("sll_zero", 64'h8000_0000_0000_0001, 64'd1, 3'b100, 64'd2, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 3'($urandom_range(7, 0));
      case ($urandom_range(7, 0))
        0: rb = ra;
        1: rb = 64'($urandom_range(127, 0));
        2: ra = ~ra & 64'hFFFF_FFFF_FFFF_FFFF;
        3: rb = -ra;
        default: ;
      endcase
      run_op("rand", ra, rb, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
